// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO sitting between the
//             UART receiver/transmitter and the host side. Storage is a plain
//             register array; a pointer/flag unit tracks head, tail and the
//             registered full/empty flags.
//  Ports    : clk      - system clock, rising-edge active
//             reset_n  - asynchronous active-low reset (pointers and flags)
//             wr       - write request, pushes w_data when accepted
//             rd       - read request, pops the head word when accepted
//             w_data   - word to be written            [DATA_WIDTH-1:0]
//             r_data   - current head word, combinational [DATA_WIDTH-1:0]
//             full     - FIFO holds 2**ADDR_WIDTH words
//             empty    - FIFO holds no words
//  Revision : 1.0  initial release
// ============================================================================
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
);

    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    // Storage array; contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;

    // A write while full is still accepted when paired with a read: the pop
    // frees the head slot, which is exactly where the write pointer sits.
    assign w_wr_ok      = wr & (~full_q | rd);
    assign w_rd_ok      = rd & ~empty_q;
    assign w_wr_ptr_inc = wr_ptr_q + 1'b1;
    assign w_rd_ptr_inc = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;

        if (w_wr_ok) begin
            wr_ptr_d = w_wr_ptr_inc;
        end
        if (w_rd_ok) begin
            rd_ptr_d = w_rd_ptr_inc;
        end

        // Occupancy only changes when exactly one side moves; a simultaneous
        // push and pop leaves both flags as they were.
        if (w_wr_ok && !w_rd_ok) begin
            empty_d = 1'b0;
            full_d  = (w_wr_ptr_inc == rd_ptr_q);
        end else if (w_rd_ok && !w_wr_ok) begin
            full_d  = 1'b0;
            empty_d = (w_rd_ptr_inc == wr_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    assign r_data = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo
//  Purpose  : Directed self-checking bench for uart_fifo (8 x 8 default).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    uart_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .w_data  (w_data),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic e, input logic f);
        chk({tag, "_empty"}, {7'd0, empty}, {7'd0, e});
        chk({tag, "_full"},  {7'd0, full},  {7'd0, f});
    endtask

    // One clock with the given request pattern; inputs return idle after.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr     = w;
        rd     = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, 1'b0, d);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, r_data, exp);
        cyc(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        reset_n = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = 8'h00;

        // Asynchronous reset, observed before any clock edge.
        #2 reset_n = 1'b0;
        #1 flags("reset", 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        flags("idle", 1'b1, 1'b0);

        // Write 5, 8, 2 then one read.
        push(8'd5); push(8'd8); push(8'd2);
        chk("head5", r_data, 8'd5);
        flags("three", 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("head8", r_data, 8'd8);
        flags("two", 1'b0, 1'b0);

        // Fill to eight words.
        push(8'd0); push(8'd9); push(8'd3); push(8'd6); push(8'd1);
        flags("seven", 1'b0, 1'b0);
        push(8'd3);
        flags("full8", 1'b0, 1'b1);
        push(8'hAA);
        flags("wr_full", 1'b0, 1'b1);
        chk("head_after_ovf", r_data, 8'd8);

        // Drain all eight.
        pop_chk("d0", 8'd8);
        flags("after_first_pop", 1'b0, 1'b0);
        pop_chk("d1", 8'd2);
        pop_chk("d2", 8'd0);
        pop_chk("d3", 8'd9);
        pop_chk("d4", 8'd3);
        pop_chk("d5", 8'd6);
        pop_chk("d6", 8'd1);
        flags("one_left", 1'b0, 1'b0);
        pop_chk("d7", 8'd3);
        flags("drained", 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        flags("rd_empty", 1'b1, 1'b0);

        // Simultaneous wr/rd on an empty FIFO: write only.
        cyc(1'b1, 1'b1, 8'd7);
        flags("wrrd_empty", 1'b0, 1'b0);
        chk("head7", r_data, 8'd7);
        cyc(1'b0, 1'b1, 8'h00);
        flags("pop7", 1'b1, 1'b0);

        // Simultaneous wr/rd in the middle.
        push(8'd4); push(8'd5); push(8'd6);
        chk("head4", r_data, 8'd4);
        cyc(1'b1, 1'b1, 8'd7);
        flags("wrrd_mid", 1'b0, 1'b0);
        pop_chk("m0", 8'd5);
        pop_chk("m1", 8'd6);
        flags("m_one_left", 1'b0, 1'b0);
        pop_chk("m2", 8'd7);
        flags("m_drained", 1'b1, 1'b0);

        // Reset mid-operation discards words immediately.
        push(8'h21); push(8'h22);
        #2 reset_n = 1'b0;
        #1 flags("mid_reset", 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        push(8'h3C);
        chk("head_post_reset", r_data, 8'h3C);
        flags("post_reset", 1'b0, 1'b0);

        // Fill, then simultaneous wr/rd while full.
        for (int i = 1; i <= 7; i++) push(8'h10 + 8'(i));
        flags("full_again", 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'hEE);
        flags("wrrd_full", 1'b0, 1'b1);
        chk("head_wrrd_full", r_data, 8'h11);
        for (int i = 1; i <= 7; i++) pop_chk("f", 8'h10 + 8'(i));
        pop_chk("f_last", 8'hEE);
        flags("f_drained", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Synchronous single-clock FIFO buffer used in the UART datapath between the receiver/transmitter and the host side. It stores up to 2^addr_width words of data_width bits and presents the oldest word combinationally on r_data (first-word-fall-through). It is built from a register-file storage array plus a pointer/flag control unit.

Parameters:
data_width, 8, width in bits of each stored word.
addr_width, 3, pointer width; depth = 2^addr_width (default 8 entries).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
wr  input  1  write request; pushes w_data on the rising edge when accepted.
rd  input  1  read request; pops the head word on the rising edge when accepted.
w_data  input  data_width  data to be written.
r_data  output  data_width  current head (oldest) word, combinational from storage at read pointer.
full  output  1  high when FIFO holds 2^addr_width words.
empty  output  1  high when FIFO holds 0 words.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset (reset_n=0, any time, independent of clk): write pointer=0, read pointer=0, empty=1, full=0. Storage contents are not reset. Reset mid-operation discards all stored words immediately.
- Storage: 2^addr_width x data_width register array; written at write pointer on rising clk when write accepted.
- r_data = storage[read pointer], combinational, no read latency; the head word is valid whenever empty=0. r_data value is don't-care while empty=1.
- Pointers are addr_width bits and wrap modulo 2^addr_width (7 -> 0 at default).
- Write accepted when wr=1 and full=0: store w_data, write pointer +1, empty<=0; full<=1 if new write pointer equals read pointer.
- Read accepted when rd=1 and empty=0: read pointer +1, full<=0; empty<=1 if new read pointer equals write pointer.
- wr=1 while full and rd=0: ignored; pointers, flags, contents unchanged.
- rd=1 while empty and wr=0: ignored; pointers and flags unchanged.
- wr=1 and rd=1 together:
  - not empty and not full: both occur; both pointers advance; full and empty unchanged.
  - empty: write only; word stored, write pointer +1, empty<=0, read pointer unchanged; r_data shows new word next cycle.
  - full: both occur; head popped, w_data stored in freed slot; full stays 1.
- full and empty are registered outputs, never both 1.
- Flags and r_data change only on rising clk edges or on reset assertion.

Test Plan:
- Reset then idle: assert reset_n=0 -> empty=1, full=0; release and hold wr=rd=0 several cycles -> flags unchanged.
- Write 5, 8, 2 then one read -> r_data=5 before the read, r_data=8 after; empty=0, full=0.
- Continue writing 0, 9, 3, 6, 1, 3 (8 words held) -> full=1 after last write; extra write of 0xAA while full -> ignored, full stays 1, contents unchanged.
- Eight consecutive reads -> r_data sequence 8, 2, 0, 9, 3, 6, 1, 3; empty=1 after eighth read, full=0 after first; additional read while empty -> no pointer change, empty stays 1.
- Empty FIFO, wr=rd=1 with w_data=7 -> write only; next cycle empty=0, r_data=7; then read -> empty=1.
- Write 4, 5, 6 then wr=rd=1 with w_data=7 -> 4 popped, 7 stored; r_data=5, count stays 3; drain yields 5, 6, 7; also assert reset_n mid-sequence -> empty=1 immediately, next write lands at index 0.
